// File: rtl/mti_mofn_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mti_mofn_detect                                                          |
// | M-of-N sliding-window integrator with run-to-event conversion and a      |
// | valid/ack event holding register. Optional event counter is enabled by   |
// | the MTI_EVT_COUNT_EN macro.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mti_mofn_detect #(
  parameter int WIN_N = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             stream,
  input  logic [5:0]       m_thresh,
  output logic [5:0]       win_count,
  output logic             hit,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_start,
  output logic [IDX_W-1:0] evt_width,
  input  logic             evt_ack,
  output logic             evt_ovf,
  output logic [15:0]      evt_count
);

  localparam logic [IDX_W-1:0] c_IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIN_N-1:0] r_win;
  logic [5:0]       r_cnt;
  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_run_start;
  logic [IDX_W-1:0] r_run_width;
  logic             r_evt_valid;
  logic [IDX_W-1:0] r_evt_start;
  logic [IDX_W-1:0] r_evt_width;
  logic             r_ovf;

  logic [5:0]       w_cnt_next;
  logic             w_hit_next;
  logic             w_load;

  // Running count: add the incoming bit, drop the one falling off the end.
  assign w_cnt_next = r_cnt + {5'd0, stream} - {5'd0, r_win[WIN_N-1]};
  assign w_hit_next = (m_thresh != 6'd0) && (w_cnt_next >= m_thresh);
  assign w_load     = (r_state == S_EMIT) && (!r_evt_valid || evt_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_cnt       <= 6'd0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_run_start <= '0;
      r_run_width <= '0;
      r_evt_valid <= 1'b0;
      r_evt_start <= '0;
      r_evt_width <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (evt_ack) r_evt_valid <= 1'b0;
      if (frame_start) begin
        r_win   <= '0;
        r_cnt   <= 6'd0;
        r_hit   <= 1'b0;
        r_idx   <= '0;
        r_state <= S_IDLE;
        r_ovf   <= 1'b0;
      end else begin
        if (bit_valid) begin
          r_win <= {r_win[WIN_N-2:0], stream};
          r_cnt <= w_cnt_next;
          r_hit <= w_hit_next;
          if (!(&r_idx)) r_idx <= r_idx + c_IDX_ONE;
        end
        case (r_state)
          S_IDLE: begin
            if (bit_valid && w_hit_next) begin
              r_run_start <= r_idx;
              r_run_width <= c_IDX_ONE;
              r_state     <= S_RUN;
            end
          end
          S_RUN: begin
            if (bit_valid) begin
              if (w_hit_next) begin
                if (!(&r_run_width)) r_run_width <= r_run_width + c_IDX_ONE;
              end else begin
                r_state <= S_EMIT;
              end
            end
          end
          S_EMIT: begin
            if (w_load) begin
              r_evt_valid <= 1'b1;
              r_evt_start <= r_run_start;
              r_evt_width <= r_run_width;
            end else begin
              r_ovf <= 1'b1;
            end
            // A new run may begin on the very sample following the emit.
            if (bit_valid && w_hit_next) begin
              r_run_start <= r_idx;
              r_run_width <= c_IDX_ONE;
              r_state     <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MTI_EVT_COUNT_EN
  logic [15:0] r_evt_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_evt_count <= 16'h0000;
    end else if (frame_start) begin
      r_evt_count <= 16'h0000;
    end else if (w_load && (r_evt_count != 16'hFFFF)) begin
      r_evt_count <= r_evt_count + 16'h0001;
    end
  end

  assign evt_count = r_evt_count;
`else
  assign evt_count = 16'h0000;
`endif

  assign win_count = r_cnt;
  assign hit       = r_hit;
  assign evt_valid = r_evt_valid;
  assign evt_start = r_evt_start;
  assign evt_width = r_evt_width;
  assign evt_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mti_mofn_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mti_mofn_detect                                                       |
// | Self-checking bench with directed scenarios and a randomized run checked |
// | against a queue-based window/run model.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mti_mofn_detect;

  localparam int WIN_N = 16;
  localparam int IDX_W = 16;
  localparam int IMAX  = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        bit_valid;
  logic        stream;
  logic [5:0]  m_thresh;
  logic [5:0]  win_count;
  logic        hit;
  logic        evt_valid;
  logic [15:0] evt_start;
  logic [15:0] evt_width;
  logic        evt_ack;
  logic        evt_ovf;
  logic [15:0] evt_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit mwin[$];
  int m_cnt, m_idx, m_rs, m_rw, m_ps, m_pw, m_start, m_width, m_ecnt;
  bit m_hit, m_pend, m_valid, m_ovf;

  mti_mofn_detect #(.WIN_N(WIN_N), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
    .stream(stream), .m_thresh(m_thresh), .win_count(win_count), .hit(hit),
    .evt_valid(evt_valid), .evt_start(evt_start), .evt_width(evt_width),
    .evt_ack(evt_ack), .evt_ovf(evt_ovf), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_count();
`ifdef MTI_EVT_COUNT_EN
    return 16'(m_ecnt);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic void model_frame();
    mwin.delete();
    for (int k = 0; k < WIN_N; k++) mwin.push_back(1'b0);
    m_cnt = 0; m_hit = 0; m_idx = 0; m_pend = 0; m_ovf = 0; m_ecnt = 0;
  endfunction

  function automatic void model_reset();
    model_frame();
    m_valid = 0; m_start = 0; m_width = 0; m_rs = 0; m_rw = 0;
  endfunction

  // Effect of one clock edge: events are the maximal runs of hit samples,
  // offered to the holding register one clock after the run ends.
  function automatic void model_edge(bit fs, bit bv, bit s, int m, bit ack);
    bit nv;
    bit nh;
    int c;
    nv = m_valid;
    if (ack) nv = 0;
    if (fs) begin
      model_frame();
    end else begin
      if (m_pend) begin
        if (!m_valid || ack) begin
          nv = 1; m_start = m_ps; m_width = m_pw;
          if (m_ecnt < 65535) m_ecnt++;
        end else begin
          m_ovf = 1;
        end
        m_pend = 0;
      end
      if (bv) begin
        mwin.push_back(s);
        void'(mwin.pop_front());
        c = 0;
        foreach (mwin[k]) c += int'(mwin[k]);
        nh = (m != 0) && (c >= m);
        if (nh && !m_hit) begin
          m_rs = m_idx; m_rw = 1;
        end else if (nh && m_hit) begin
          if (m_rw < IMAX) m_rw++;
        end else if (!nh && m_hit) begin
          m_pend = 1; m_ps = m_rs; m_pw = m_rw;
        end
        m_cnt = c; m_hit = nh;
        if (m_idx < IMAX) m_idx++;
      end
    end
    m_valid = nv;
  endfunction

  task automatic step(input bit fs, input bit bv, input bit s, input int m, input bit ack);
    @(negedge clk);
    frame_start = fs; bit_valid = bv; stream = s; m_thresh = 6'(m); evt_ack = ack;
    @(posedge clk);
    model_edge(fs, bv, s, m, ack);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_start = 0; bit_valid = 0; stream = 0; m_thresh = 0; evt_ack = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (win_count !== 6'd0) begin errors++; $display("FAIL reset_win_count: got %0d expected 0", win_count); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b expected 0", hit); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %0b expected 0", evt_valid); end
    checks++; if ({evt_start, evt_width} !== 32'd0) begin errors++; $display("FAIL reset_fields: got %0d/%0d expected 0/0", evt_start, evt_width); end
    checks++; if ({evt_ovf, evt_count} !== 17'd0) begin errors++; $display("FAIL reset_ovf_count: got %0b/%0d expected 0/0", evt_ovf, evt_count); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_event();
    step(1, 0, 0, 3, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 1, (i >= 5 && i <= 7), 3, 0);
      if (i == 6) begin
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL basic_hit_before: got %0b expected 0", hit); end
      end
      if (i == 7) begin
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL basic_hit_rise: got %0b expected 1", hit); end
        checks++; if (win_count !== 6'd3) begin errors++; $display("FAIL basic_win_count: got %0d expected 3", win_count); end
      end
      if (i == 20) begin
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL basic_hit_hold: got %0b expected 1", hit); end
      end
      if (i == 21) begin
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL basic_hit_fall: got %0b expected 0", hit); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %0b expected 0", evt_valid); end
      end
      if (i == 22) begin
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_t2: got %0b expected 1", evt_valid); end
        checks++; if (evt_start !== 16'd7 || evt_width !== 16'd14) begin errors++; $display("FAIL basic_fields: got %0d/%0d expected 7/14", evt_start, evt_width); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 24; i < 60; i++) step(0, 1, (i >= 40 && i <= 42), 3, 0);
    checks++; if (evt_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", evt_ovf); end
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'd7 || evt_width !== 16'd14) begin
      errors++; $display("FAIL ovf_fields_held: got v=%0b %0d/%0d expected v=1 7/14", evt_valid, evt_start, evt_width); end
    step(0, 0, 0, 3, 1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_ack_clear: got %0b expected 0", evt_valid); end
    checks++; if (evt_count !== exp_count() || m_ecnt != 1) begin errors++; $display("FAIL ovf_evt_count: got %0d expected %0d", evt_count, exp_count()); end
    step(0, 0, 0, 3, 1);
    checks++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b1) begin errors++; $display("FAIL ack_idle_ignored: got v=%0b ovf=%0b expected v=0 ovf=1", evt_valid, evt_ovf); end
  endtask

  task automatic test_thresh();
    int bad;
    for (int t = 0; t < 2; t++) begin
      bad = 0;
      step(1, 0, 0, (t == 0) ? 0 : 17, 0);
      for (int i = 0; i < 100; i++) begin
        step(0, 1, 1, (t == 0) ? 0 : 17, 0);
        if (hit !== 1'b0 || evt_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL thresh_disabled_m%0d: got %0d samples with hit/event expected 0", (t == 0) ? 0 : 17, bad); end
    end
    step(1, 0, 0, 16, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 16, 0);
      if (i == 14) begin
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL thresh16_early: got %0b expected 0", hit); end
      end
    end
    checks++; if (hit !== 1'b1 || win_count !== 6'd16) begin errors++; $display("FAIL thresh16_hit: got hit=%0b cnt=%0d expected 1/16", hit, win_count); end
  endtask

  task automatic test_frame_start();
    step(1, 0, 0, 2, 1);
    for (int b = 0; b < 2; b++) begin
      step(0, 1, 1, 2, 0); step(0, 1, 1, 2, 0);
      repeat (17) step(0, 1, 0, 2, 0);
    end
    checks++; if (evt_ovf !== 1'b1 || evt_start !== 16'd1 || evt_width !== 16'd15) begin
      errors++; $display("FAIL fs_setup: got ovf=%0b %0d/%0d expected ovf=1 1/15", evt_ovf, evt_start, evt_width); end
    repeat (3) step(0, 1, 1, 2, 0);
    step(1, 1, 1, 2, 0);
    checks++; if (win_count !== 6'd0 || hit !== 1'b0) begin errors++; $display("FAIL fs_window_clear: got cnt=%0d hit=%0b expected 0/0", win_count, hit); end
    checks++; if (evt_ovf !== 1'b0) begin errors++; $display("FAIL fs_ovf_clear: got %0b expected 0", evt_ovf); end
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'd1) begin errors++; $display("FAIL fs_pending_kept: got v=%0b start=%0d expected 1/1", evt_valid, evt_start); end
    repeat (20) step(0, 0, 0, 2, 0);
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'd1 || evt_width !== 16'd15 || evt_ovf !== 1'b0) begin
      errors++; $display("FAIL fs_run_aborted: got v=%0b %0d/%0d ovf=%0b expected 1 1/15 0", evt_valid, evt_start, evt_width, evt_ovf); end
    step(0, 1, 1, 1, 1);
    repeat (17) step(0, 1, 0, 1, 0);
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'd0 || evt_width !== 16'd16) begin
      errors++; $display("FAIL fs_index_restart: got v=%0b %0d/%0d expected 1 0/16", evt_valid, evt_start, evt_width); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 1, 1);
    step(0, 1, 1, 1, 0);
    repeat (17) step(0, 1, 0, 1, 0);
    repeat (3) step(0, 1, 1, 1, 0);
    checks++; if (evt_valid !== 1'b1 || hit !== 1'b1) begin errors++; $display("FAIL areset_setup: got v=%0b hit=%0b expected 1/1", evt_valid, hit); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if ({win_count, hit, evt_valid, evt_ovf} !== 9'd0 || {evt_start, evt_width, evt_count} !== 48'd0) begin
      errors++; $display("FAIL areset_immediate: got cnt=%0d hit=%0b v=%0b %0d/%0d ovf=%0b n=%0d expected all 0",
                         win_count, hit, evt_valid, evt_start, evt_width, evt_ovf, evt_count); end
    @(negedge clk);
    frame_start = 0; bit_valid = 0; stream = 0; evt_ack = 0;
    reset = 1'b1;
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    repeat (17) step(0, 1, 0, 1, 0);
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'd0 || evt_width !== 16'd16) begin
      errors++; $display("FAIL areset_index0: got v=%0b %0d/%0d expected 1 0/16", evt_valid, evt_start, evt_width); end
  endtask

  task automatic test_random();
    int m, p;
    bit bv, s, ack, fs;
    step(1, 0, 0, 0, 1);
    for (int seg = 0; seg < 40; seg++) begin
      m = $urandom_range(0, 18);
      p = $urandom_range(10, 90);
      for (int i = 0; i < 60; i++) begin
        bv  = ($urandom % 4) != 0;
        s   = ($urandom % 100) < p;
        ack = ($urandom % 5) == 0;
        fs  = ($urandom % 200) == 0;
        step(fs, bv, s, m, ack);
        checks++; if (win_count !== 6'(m_cnt)) begin errors++; $display("FAIL rnd_win_count: got %0d expected %0d", win_count, m_cnt); end
        checks++; if (hit !== m_hit) begin errors++; $display("FAIL rnd_hit: got %0b expected %0b", hit, m_hit); end
        checks++; if (evt_valid !== m_valid) begin errors++; $display("FAIL rnd_evt_valid: got %0b expected %0b", evt_valid, m_valid); end
        checks++; if (evt_ovf !== m_ovf) begin errors++; $display("FAIL rnd_evt_ovf: got %0b expected %0b", evt_ovf, m_ovf); end
        checks++; if (evt_count !== exp_count()) begin errors++; $display("FAIL rnd_evt_count: got %0d expected %0d", evt_count, exp_count()); end
        if (m_valid) begin
          checks++; if (evt_start !== 16'(m_start) || evt_width !== 16'(m_width)) begin
            errors++; $display("FAIL rnd_evt_fields: got %0d/%0d expected %0d/%0d", evt_start, evt_width, m_start, m_width); end
        end
      end
    end
  endtask

  task automatic test_back_to_back_saturation();
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 70000; i++) step(0, 1, 1, 1, 0);
    checks++; if (hit !== 1'b1 || win_count !== 6'd16) begin errors++; $display("FAIL sat_run: got hit=%0b cnt=%0d expected 1/16", hit, win_count); end
    repeat (20) step(0, 1, 0, 1, 0);
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'd0 || evt_width !== 16'hFFFF) begin
      errors++; $display("FAIL sat_width: got v=%0b %0d/%0h expected 1 0/ffff", evt_valid, evt_start, evt_width); end
    step(0, 0, 0, 1, 1);
    step(0, 1, 1, 1, 0);
    repeat (17) step(0, 1, 0, 1, 0);
    checks++; if (evt_valid !== 1'b1 || evt_start !== 16'hFFFF || evt_width !== 16'd16) begin
      errors++; $display("FAIL sat_index: got v=%0b %0h/%0d expected 1 ffff/16", evt_valid, evt_start, evt_width); end
    checks++; if (evt_count !== exp_count()) begin errors++; $display("FAIL sat_evt_count: got %0d expected %0d", evt_count, exp_count()); end
  endtask

  initial begin
    test_reset();
    test_basic_event();
    test_overflow();
    test_thresh();
    test_frame_start();
    test_async_reset();
    test_random();
    test_back_to_back_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
